mips_fetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_next_pc.sv | 32 +++
 rtl/mips_fetch_unit.sv | 100 ++++++++++
 tb/tb_mips_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction fields, control-word bits
// and the fetch sequencer state encoding.
package mips_pkg;

  localparam int XLEN       = 32;
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int JUMP_BIT   = 1;
  localparam int BRANCH_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC selection: jump target, taken branch or sequential pc+4.
// Purely combinational; all arithmetic wraps modulo 2^32.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_ir,
  input  logic            i_jump,
  input  logic            i_branch,
  input  logic            i_zero,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_boff;
  logic [XLEN-1:0] w_jtgt;

  assign w_pc4  = i_pc + 32'd4;
  assign w_boff = {{14{i_ir[15]}}, i_ir[15:0], 2'b00};
  assign w_jtgt = {w_pc4[31:28], i_ir[25:0], 2'b00};

  // Jump outranks branch when the controller raises both.
  always_comb begin
    o_next_pc = w_pc4;
    if (i_jump) begin
      o_next_pc = w_jtgt;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_pc4 + w_boff;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch sequencer: owns PC and IR, fetches over a
// req/ready handshake and traps on an unanswered request.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic        ir_valid,
  input  logic        ir_ack,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic        imem_err
);

  localparam logic [7:0] W_LAST = 8'(WAIT_LIMIT - 1);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [7:0]   r_cnt;
  logic [31:0]  w_next_pc;
  logic [1:0]   w_ctrl;

  assign w_ctrl[JUMP_BIT]   = jump;
  assign w_ctrl[BRANCH_BIT] = branch;

  mips_next_pc u_next_pc (
    .i_pc      (r_pc),
    .i_ir      (r_ir),
    .i_jump    (w_ctrl[JUMP_BIT]),
    .i_branch  (w_ctrl[BRANCH_BIT]),
    .i_zero    (zero),
    .o_next_pc (w_next_pc)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: w_next_state = REQ;
      REQ: begin
        if (imem_ready) begin
          w_next_state = HOLD;
        end else if (r_cnt == W_LAST) begin
          w_next_state = ERR;
        end
      end
      HOLD: begin
        if (ir_ack) begin
          w_next_state = REQ;
        end
      end
      ERR:     w_next_state = ERR;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == REQ) begin
        if (imem_ready) begin
          r_ir  <= imem_rdata;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      if (r_state == HOLD && ir_ack) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign imem_req  = (r_state == REQ);
  assign ir_valid  = (r_state == HOLD);
  assign imem_err  = (r_state == ERR);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign opcode    = r_ir[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: fetch sequencing, branches,
// jump priority, wait states, timeout trap, wrap and async reset.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        ir_valid;
  logic        ir_ack;
  logic        jump;
  logic        branch;
  logic        zero;
  logic        imem_err;

  logic [31:0] np_pc;
  logic [31:0] np_ir;
  logic        np_j;
  logic        np_b;
  logic        np_z;
  logic [31:0] np_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .WAIT_LIMIT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .ir_valid   (ir_valid),
    .ir_ack     (ir_ack),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .imem_err   (imem_err)
  );

  mips_next_pc u_np (
    .i_pc      (np_pc),
    .i_ir      (np_ir),
    .i_jump    (np_j),
    .i_branch  (np_b),
    .i_zero    (np_z),
    .o_next_pc (np_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] d);
    imem_ready = 1'b1;
    imem_rdata = d;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic ack(input logic j, input logic b, input logic z);
    ir_ack = 1'b1;
    jump   = j;
    branch = b;
    zero   = z;
    tick();
    ir_ack = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    ir_ack     = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    np_pc = '0; np_ir = '0; np_j = 1'b0; np_b = 1'b0; np_z = 1'b0;

    #12;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_err", imem_err, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_opcode", opcode, 0);
    tick();
    rst_n = 1'b1;
    chk("idle_req", imem_req, 0);
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);

    serve(32'h2008_0005);
    chk("hold_valid", ir_valid, 1);
    chk("hold_opcode", opcode, 6'b001000);
    chk("hold_ir", ir, 32'h2008_0005);
    chk("hold_req", imem_req, 0);

    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ready = 1'b0;
    chk("ready_in_hold_ir", ir, 32'h2008_0005);
    chk("ready_in_hold_pc", pc, 32'h0);
    chk("ready_in_hold_valid", ir_valid, 1);

    ack(1'b0, 1'b0, 1'b0);
    chk("seq_req", imem_req, 1);
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_valid_drop", ir_valid, 0);

    ir_ack = 1'b1;
    jump   = 1'b1;
    serve(32'h2008_0005);
    ir_ack = 1'b0;
    jump   = 1'b0;
    chk("ack_in_req_pc", pc, 32'h4);
    chk("ack_in_req_valid", ir_valid, 1);
    ack(1'b0, 1'b0, 1'b0);
    chk("seq_addr8", imem_addr, 32'h8);

    serve(32'h0800_0040);
    ack(1'b1, 1'b0, 1'b0);
    chk("jump_0x100", imem_addr, 32'h100);

    serve(32'h1000_FFFE);
    ack(1'b0, 1'b1, 1'b1);
    chk("branch_taken", imem_addr, 32'h0FC);

    serve(32'h0800_0040);
    ack(1'b1, 1'b0, 1'b0);
    serve(32'h1000_FFFE);
    ack(1'b0, 1'b1, 1'b0);
    chk("branch_not_taken", imem_addr, 32'h104);

    serve(32'h0800_0040);
    ack(1'b1, 1'b1, 1'b1);
    chk("jump_priority", imem_addr, 32'h100);

    for (int i = 0; i < 4; i++) begin
      chk("wait_addr", imem_addr, 32'h100);
      chk("wait_req", imem_req, 1);
      tick();
    end
    serve(32'h1000_FFBE);
    chk("wait_ir", ir, 32'h1000_FFBE);
    chk("wait_valid", ir_valid, 1);
    ack(1'b0, 1'b1, 1'b1);
    chk("branch_to_top", imem_addr, 32'hFFFF_FFFC);

    serve(32'h0000_0000);
    ack(1'b0, 1'b0, 1'b0);
    chk("wrap_addr", imem_addr, 32'h0);

    for (int i = 0; i < 16; i++) begin
      chk("timeout_pending", {imem_req, imem_err}, 2'b10);
      tick();
    end
    chk("timeout_err", imem_err, 1);
    chk("timeout_req", imem_req, 0);
    chk("timeout_valid", ir_valid, 0);
    tick();
    tick();
    chk("err_sticky", {imem_req, imem_err}, 2'b01);

    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_err", imem_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 32'h0);
    serve(32'h2008_0005);
    ack(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("midwait_addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_valid", ir_valid, 0);
    chk("async_err", imem_err, 0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_ir", ir, 32'h0);
    tick();
    rst_n = 1'b1;
    chk("reidle_req", imem_req, 0);
    tick();
    chk("refetch_req", imem_req, 1);
    chk("refetch_addr", imem_addr, 32'h0);
    serve(32'h2008_0005);
    chk("refetch_valid", ir_valid, 1);

    np_pc = 32'h4000_0010;
    np_ir = 32'h0800_0040;
    np_j = 1'b1; np_b = 1'b1; np_z = 1'b1;
    #1;
    chk("np_jump_priority", np_out, 32'h4000_0100);
    np_j = 1'b0;
    #1;
    chk("np_branch", np_out, 32'h4000_0114);
    np_z = 1'b0;
    #1;
    chk("np_seq", np_out, 32'h4000_0014);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
